// File: rtl/teamj_design.sv
// Team J test-chip pad-level top: inverter, gated toggle oscillator, 4-bit ripple
// adder with carry-in and an overlapping Moore sequence detector, all on raw pins.
module teamj_design #(
    parameter logic [5:0] SEQ_PATTERN = 6'b100111,
    parameter int         SEQ_LEN     = 6
) (
    input  logic A0,  input  logic A1,  input  logic A2,  input  logic A3,
    input  logic A4,  input  logic A5,  input  logic A6,  input  logic A7,
    input  logic A8,  input  logic A9,  input  logic A10, input  logic A11,
    input  logic A12, input  logic A13, input  logic A14, input  logic A15,
    input  logic A16, input  logic A17, input  logic A18, input  logic A19,
    input  logic A20, input  logic A21, input  logic A22, input  logic A23,
    output logic Q0,  output logic Q1,  output logic Q2,  output logic Q3,
    output logic Q4,  output logic Q5,  output logic Q6,  output logic Q7,
    output logic Q8,  output logic Q9,  output logic Q10, output logic Q11,
    output logic Q12, output logic Q13, output logic Q14, output logic Q15,
    output logic Q16, output logic Q17, output logic Q18, output logic Q19,
    output logic Q20, output logic Q21, output logic Q22, output logic Q23
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'(SEQ_LEN);

    logic       r_osc;
    logic [2:0] r_state;
    logic       r_match;
    logic [2:0] w_next;
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [3:0] w_sum;
    logic       w_cout;
    logic       w_unused;

    assign Q0 = ~A0;

    // A1 is the oscillator's own clear; the detector reset A13 never touches it.
    always_ff @(posedge A12 or negedge A1) begin
        if (!A1) begin
            r_osc <= 1'b0;
        end else if (A2) begin
            // NOTE: clocked state always uses <= so every flop samples pre-edge values.
            r_osc <= ~r_osc;
        end
    end

    assign Q1 = r_osc;

    assign w_x = {A7, A6, A5, A4};
    assign w_y = {A11, A10, A9, A8};

    always_comb begin
        // NOTE: blocking = is correct here; the carry must ripple stage to stage in order.
        w_cout = A3;
        w_sum  = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = w_x[i] ^ w_y[i] ^ w_cout;
            w_cout   = (w_x[i] & w_y[i]) | (w_cout & (w_x[i] ^ w_y[i]));
        end
    end

    assign {Q7, Q6, Q5, Q4, Q3} = {w_cout, w_sum};

    // Forward edges follow SEQ_PATTERN; fall-back targets are the KMP failure states
    // worked out for 100111 and must be re-derived if the pattern changes.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next = S0;
        case (r_state)
            S0:      w_next = (A14 == SEQ_PATTERN[5]) ? S1 : S0;
            S1:      w_next = (A14 == SEQ_PATTERN[4]) ? S2 : S1;
            S2:      w_next = (A14 == SEQ_PATTERN[3]) ? S3 : S1;
            S3:      w_next = (A14 == SEQ_PATTERN[2]) ? S4 : S0;
            S4:      w_next = (A14 == SEQ_PATTERN[1]) ? S5 : S2;
            S5:      w_next = (A14 == SEQ_PATTERN[0]) ? S6 : S2;
            S6:      w_next = (A14 == SEQ_PATTERN[5]) ? S1 : S2;
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge A12 or negedge A13) begin
        if (!A13) begin
            r_state <= S0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_next;
            r_match <= (w_next == S6);
        end
    end

    assign Q12 = r_match;

    assign Q2  = 1'b0;
    assign Q8  = 1'b0;
    assign Q9  = 1'b0;
    assign Q10 = 1'b0;
    assign Q11 = 1'b0;
    assign Q13 = 1'b0;
    assign Q14 = 1'b0;
    assign Q15 = 1'b0;
    assign Q16 = 1'b0;
    assign Q17 = 1'b0;
    assign Q18 = 1'b0;
    assign Q19 = 1'b0;
    assign Q20 = 1'b0;
    assign Q21 = 1'b0;
    assign Q22 = 1'b0;
    assign Q23 = 1'b0;

    assign w_unused = ^{A15, A16, A17, A18, A19, A20, A21, A22, A23};

endmodule

// File: tb/tb_teamj_design.sv
// Bench for teamj_design: directed pin-level steps plus random detector traffic
// scored against a last-six-bits history model.
module tb_teamj_design;

    logic A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10, A11;
    logic A12, A13, A14, A15, A16, A17, A18, A19, A20, A21, A22, A23;
    logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9, Q10, Q11;
    logic Q12, Q13, Q14, Q15, Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23;

    int checks   = 0;
    int failures = 0;

    logic [5:0]  m_hist;
    int          m_cnt;
    logic        m_osc;
    logic [53:0] stream   = 54'b111100101110010111101110010111001110010111100111100101;
    logic [53:0] pos_mask;
    logic [5:0]  target   = 6'b100111;

    teamj_design dut (
        .A0(A0),   .A1(A1),   .A2(A2),   .A3(A3),   .A4(A4),   .A5(A5),
        .A6(A6),   .A7(A7),   .A8(A8),   .A9(A9),   .A10(A10), .A11(A11),
        .A12(A12), .A13(A13), .A14(A14), .A15(A15), .A16(A16), .A17(A17),
        .A18(A18), .A19(A19), .A20(A20), .A21(A21), .A22(A22), .A23(A23),
        .Q0(Q0),   .Q1(Q1),   .Q2(Q2),   .Q3(Q3),   .Q4(Q4),   .Q5(Q5),
        .Q6(Q6),   .Q7(Q7),   .Q8(Q8),   .Q9(Q9),   .Q10(Q10), .Q11(Q11),
        .Q12(Q12), .Q13(Q13), .Q14(Q14), .Q15(Q15), .Q16(Q16), .Q17(Q17),
        .Q18(Q18), .Q19(Q19), .Q20(Q20), .Q21(Q21), .Q22(Q22), .Q23(Q23)
    );

    initial A12 = 1'b0;
    always #50 A12 = ~A12;

    initial begin
        #5ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] unused_q();
        return {18'd0, Q2, Q8, Q9, Q10, Q11, Q13, Q14, Q15, Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23};
    endfunction

    function automatic logic model_match();
        return (m_cnt >= 6) && (m_hist == target);
    endfunction

    // Called just after a falling edge; data is stable 50 ns before the rising edge.
    task automatic shift_bit(input logic b);
        A14 = b;
        @(posedge A12);
        @(negedge A12);
        m_hist = {m_hist[4:0], b};
        m_cnt  = (m_cnt < 100) ? m_cnt + 1 : m_cnt;
        check("det_match", Q12, model_match());
    endtask

    task automatic pulse_det_reset();
        #10 A13 = 1'b0;
        #1 check("det_async_reset", Q12, 0);
        #9 A13 = 1'b1;
        m_cnt  = 0;
        m_hist = '0;
    endtask

    task automatic shift_word(input logic [5:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    initial begin
        {A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10, A11} = '0;
        {A13, A14, A15, A16, A17, A18, A19, A20, A21, A22, A23} = '0;
        pos_mask = '0;
        pos_mask[7] = 1'b1;  pos_mask[13] = 1'b1; pos_mask[21] = 1'b1; pos_mask[26] = 1'b1;
        pos_mask[33] = 1'b1; pos_mask[45] = 1'b1; pos_mask[52] = 1'b1;
        m_hist = '0;
        m_cnt  = 0;

        #20;
        check("reset_q1", Q1, 0);
        check("reset_q12", Q12, 0);
        check("reset_unused", unused_q(), 0);

        for (int i = 0; i < 8; i++) begin
            A0 = i[0];
            #1 check("inverter", Q0, {31'd0, ~i[0]});
        end

        // Oscillator: enable low holds, enable high toggles, A1 clears asynchronously.
        @(negedge A12);
        A1 = 1'b1; A13 = 1'b1; A2 = 1'b0;
        m_osc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge A12);
            check("osc_hold", Q1, m_osc);
        end
        A2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge A12);
            m_osc = ~m_osc;
            check("osc_toggle", Q1, m_osc);
        end
        #10 A1 = 1'b0;
        #1 check("osc_async_clear", Q1, 0);
        @(posedge A12);
        #1 check("osc_clear_priority", Q1, 0);
        @(negedge A12);
        A1 = 1'b1;
        m_osc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            A2 = 1'($urandom_range(0, 1));
            A13 = 1'($urandom_range(0, 1));
            @(negedge A12);
            if (A2) m_osc = ~m_osc;
            check("osc_random_enable", Q1, m_osc);
        end
        A2 = 1'b0;
        A13 = 1'b1;

        // Adder: every operand/carry combination, with unused pins scrambled.
        for (int v = 0; v < 512; v++) begin
            {A7, A6, A5, A4}   = 4'(v >> 5);
            {A11, A10, A9, A8} = 4'(v >> 1);
            A3 = v[0];
            {A15, A16, A17, A18, A19, A20, A21, A22, A23} = 9'($urandom);
            #1 check("adder", {27'd0, Q7, Q6, Q5, Q4, Q3}, (v >> 5) + ((v >> 1) & 15) + (v & 1));
        end
        check("unused_after_scramble", unused_q(), 0);
        {A7, A6, A5, A4, A11, A10, A9, A8, A3} = 9'b1111_1111_1;
        #1 check("adder_max", {27'd0, Q7, Q6, Q5, Q4, Q3}, 31);
        {A7, A6, A5, A4, A11, A10, A9, A8, A3} = 9'b1000_1000_0;
        #1 check("adder_16", {27'd0, Q7, Q6, Q5, Q4, Q3}, 16);

        // Detector: reference stream with known match positions.
        @(negedge A12);
        pulse_det_reset();
        for (int i = 0; i < 54; i++) begin
            shift_bit(stream[i]);
            check("stream_position", Q12, pos_mask[i]);
        end

        pulse_det_reset();
        shift_word(6'b010011, 5);
        pulse_det_reset();
        shift_bit(1'b1);
        check("prefix_lost_after_reset", Q12, 0);
        shift_word(6'b100111, 6);
        check("match_after_reset", Q12, 1);

        pulse_det_reset();
        shift_word(6'b100111, 6);
        check("overlap_first", Q12, 1);
        shift_word(6'b000111, 5);
        check("overlap_second", Q12, 1);
        shift_bit(1'b0);
        check("match_one_cycle", Q12, 0);

        pulse_det_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_det_reset();
            if ($urandom_range(0, 9) == 0) shift_word(6'b100111, 6);
            else shift_bit(1'($urandom_range(0, 1)));
        end
        check("unused_final", unused_q(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
